// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter and burst sequencer for a 32x32 single-port SRAM.
// Grants at burst boundaries; read words return to their owner RD_LAT+1 cycles after issue.
module sram_port_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rq0_valid,
    output logic        rq0_ready,
    input  logic        rq0_we,
    input  logic [4:0]  rq0_addr,
    input  logic [1:0]  rq0_len,
    input  logic [31:0] rq0_wdata,
    output logic        rq0_wack,
    output logic [31:0] rq0_rdata,
    output logic        rq0_rvalid,
    input  logic        rq1_valid,
    output logic        rq1_ready,
    input  logic        rq1_we,
    input  logic [4:0]  rq1_addr,
    input  logic [1:0]  rq1_len,
    input  logic [31:0] rq1_wdata,
    output logic        rq1_wack,
    output logic [31:0] rq1_rdata,
    output logic        rq1_rvalid,
    output logic        busy,
    output logic        csb_n,
    output logic        we_n,
    output logic [4:0]  addr,
    output logic [31:0] sram_data_in,
    input  logic [31:0] sram_data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    genvar gi;

    logic [1:0]  valid_w;
    logic [1:0]  we_w;
    logic [4:0]  addr_w  [2];
    logic [1:0]  len_w   [2];
    logic [31:0] wdata_w [2];

    assign valid_w    = {rq1_valid, rq0_valid};
    assign we_w       = {rq1_we, rq0_we};
    assign addr_w[0]  = rq0_addr;
    assign addr_w[1]  = rq1_addr;
    assign len_w[0]   = rq0_len;
    assign len_w[1]   = rq1_len;
    assign wdata_w[0] = rq0_wdata;
    assign wdata_w[1] = rq1_wdata;

    state_t      state_q;
    logic        owner_q;
    logic        we_q;
    logic        last_grant_q;
    logic [4:0]  addr_q;
    logic [1:0]  cnt_q;
    logic [31:0] wd_hold_q;

    // Return pipeline: one {valid, owner} stage per cycle of SRAM read latency.
    logic [RD_LAT-1:0] pv_q;
    logic [RD_LAT-1:0] pv_d;
    logic [RD_LAT-1:0] po_q;
    logic [RD_LAT-1:0] po_d;

    logic [1:0]  rvalid_q;
    logic [31:0] rdata_q [2];
    logic [1:0]  ret_hit;
    logic [1:0]  ready_w;
    logic [1:0]  wack_w;

    logic        grant_any;
    logic        grant_id;
    logic        beat;
    logic        wr_beat;
    logic        rd_beat;
    logic [31:0] wdata_sel;

    // On a tie the port that did not win last time gets the grant.
    assign grant_id  = (valid_w == 2'b11) ? ~last_grant_q : valid_w[1];
    assign grant_any = (state_q == S_IDLE) && !rst && (valid_w != 2'b00);

    assign beat      = (state_q == S_BURST);
    assign wr_beat   = beat && we_q;
    assign rd_beat   = beat && !we_q;
    assign wdata_sel = wdata_w[owner_q];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign ready_w[gi] = grant_any && (grant_id == 1'(gi));
            assign wack_w[gi]  = wr_beat && (owner_q == 1'(gi));
            assign ret_hit[gi] = pv_q[RD_LAT-1] && (po_q[RD_LAT-1] == 1'(gi));
        end
    endgenerate

    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pv_d[gi] = rd_beat;
                assign po_d[gi] = owner_q;
            end else begin : g_tail
                assign pv_d[gi] = pv_q[gi-1];
                assign po_d[gi] = po_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= 5'd0;
            cnt_q        <= 2'd0;
            wd_hold_q    <= 32'd0;
            pv_q         <= '0;
            po_q         <= '0;
        end else begin
            pv_q <= pv_d;
            po_q <= po_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        owner_q      <= grant_id;
                        we_q         <= we_w[grant_id];
                        addr_q       <= addr_w[grant_id];
                        cnt_q        <= len_w[grant_id];
                        last_grant_q <= grant_id;
                        state_q      <= S_BURST;
                    end
                end
                S_BURST: begin
                    addr_q <= addr_q + 5'd1;
                    cnt_q  <= cnt_q - 2'd1;
                    if (wr_beat) begin
                        wd_hold_q <= wdata_sel;
                    end
                    if (cnt_q == 2'd0) begin
                        state_q <= we_q ? S_IDLE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave once the final read return has shifted out.
                    if (pv_d == '0) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q   <= 2'b00;
            rdata_q[0] <= 32'd0;
            rdata_q[1] <= 32'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rvalid_q[i] <= ret_hit[i];
                if (ret_hit[i]) begin
                    rdata_q[i] <= sram_data_out;
                end
            end
        end
    end

    assign rq0_ready    = ready_w[0];
    assign rq1_ready    = ready_w[1];
    assign rq0_wack     = wack_w[0];
    assign rq1_wack     = wack_w[1];
    assign rq0_rvalid   = rvalid_q[0];
    assign rq1_rvalid   = rvalid_q[1];
    assign rq0_rdata    = rdata_q[0];
    assign rq1_rdata    = rdata_q[1];

    assign csb_n        = ~beat;
    assign we_n         = ~wr_beat;
    assign addr         = addr_q;
    assign sram_data_in = wr_beat ? wdata_sel : wd_hold_q;
    assign busy         = (state_q != S_IDLE) || (pv_q != '0);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Drives three arbiters (RD_LAT = 1, 2, 3) side by side and checks every output each
// cycle against a transaction-level schedule computed when each command is accepted.
module tb_sram_port_arbiter;

    localparam int NL = 3;
    localparam int NC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [NL-1:0] v0, v1, rdy0, rdy1, wk0, wk1, rv0, rv1, bsy, csb_n, we_n;
    logic          we0_c, we1_c;
    logic [4:0]    ad0_c, ad1_c;
    logic [1:0]    ln0_c, ln1_c;
    logic [31:0]   wd0 [NL];
    logic [31:0]   wd1 [NL];
    logic [31:0]   rd0 [NL];
    logic [31:0]   rd1 [NL];
    logic [31:0]   sdi [NL];
    logic [31:0]   sdo [NL];
    logic [4:0]    sa  [NL];
    logic [31:0]   junk;

    always @(posedge clk) junk <= $urandom;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            sram_port_arbiter #(.RD_LAT(gi + 1)) u_dut (
                .clk(clk), .rst(rst),
                .rq0_valid(v0[gi]), .rq0_ready(rdy0[gi]), .rq0_we(we0_c), .rq0_addr(ad0_c),
                .rq0_len(ln0_c), .rq0_wdata(wd0[gi]), .rq0_wack(wk0[gi]), .rq0_rdata(rd0[gi]),
                .rq0_rvalid(rv0[gi]),
                .rq1_valid(v1[gi]), .rq1_ready(rdy1[gi]), .rq1_we(we1_c), .rq1_addr(ad1_c),
                .rq1_len(ln1_c), .rq1_wdata(wd1[gi]), .rq1_wack(wk1[gi]), .rq1_rdata(rd1[gi]),
                .rq1_rvalid(rv1[gi]),
                .busy(bsy[gi]), .csb_n(csb_n[gi]), .we_n(we_n[gi]), .addr(sa[gi]),
                .sram_data_in(sdi[gi]), .sram_data_out(sdo[gi])
            );

            // SRAM macro: data for a read in cycle C is presented during cycle C+RD_LAT.
            logic [31:0] mem [32];
            logic [31:0] dd [3];
            logic [2:0]  dv;
            always @(posedge clk) begin
                if (!csb_n[gi] && !we_n[gi]) mem[sa[gi]] <= sdi[gi];
                dv    <= {dv[1:0], !csb_n[gi] && we_n[gi]};
                dd[0] <= mem[sa[gi]];
                dd[1] <= dd[0];
                dd[2] <= dd[1];
            end
            assign sdo[gi] = dv[gi] ? dd[gi] : junk;
        end
    endgenerate

    // Expected per-lane, per-cycle behaviour.
    bit          e_acc [NL][NC];
    bit          e_we  [NL][NC];
    bit          e_bz  [NL][NC];
    logic [4:0]  e_ad  [NL][NC];
    logic [31:0] e_wd  [NL][NC];
    logic [31:0] e_rd  [NL][NC];
    logic [1:0]  e_wk  [NL][NC];
    logic [1:0]  e_rv  [NL][NC];
    logic [31:0] ref_mem [NL][32];
    int          free_at [NL];
    bit          lastg [NL];
    int          wr_last [NL][2];

    logic [31:0] wb0 [4];
    logic [31:0] wb1 [4];
    int          wp0 [NL];
    int          wp1 [NL];
    bit          acc0 [NL];
    bit          acc1 [NL];
    bit          wks0 [NL];
    bit          wks1 [NL];
    bit          hold;
    int          cyc;
    int          n_vec;
    int          n_err;

    task automatic chk(input string tag, input int l, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s lane%0d cyc%0d observed=%08h expected=%08h", tag, l, cyc, obs, exp);
        end
    endtask

    task automatic schedule(input int l, input int p, input int c);
        logic        w;
        logic [4:0]  a, ad;
        logic [1:0]  n;
        logic [31:0] d;
        int t, last;
        w = p ? we1_c : we0_c;
        a = p ? ad1_c : ad0_c;
        n = p ? ln1_c : ln0_c;
        for (int k = 0; k <= int'(n); k++) begin
            t  = c + 1 + k;
            ad = a + 5'(k);
            d  = p ? wb1[k] : wb0[k];
            e_acc[l][t] = 1'b1;
            e_ad[l][t]  = ad;
            e_we[l][t]  = w;
            e_wd[l][t]  = d;
            if (w) begin
                e_wk[l][t]     = p ? 2'b10 : 2'b01;
                ref_mem[l][ad] = d;
            end else begin
                e_rv[l][t + l + 2] = p ? 2'b10 : 2'b01;
                e_rd[l][t + l + 2] = ref_mem[l][ad];
            end
        end
        last       = c + 1 + int'(n);
        free_at[l] = w ? last + 1 : last + 2 + l;
        for (int t2 = c + 1; t2 < free_at[l]; t2++) e_bz[l][t2] = 1'b1;
        lastg[l] = (p != 0);
        if (w) wr_last[l][p] = last;
    endtask

    task automatic check_cycle();
        logic [1:0] erdy;
        int p;
        for (int l = 0; l < NL; l++) begin
            erdy = 2'b00;
            p    = 0;
            if (!rst && cyc >= free_at[l] && (v0[l] || v1[l])) begin
                p    = (v0[l] && v1[l]) ? int'(!lastg[l]) : int'(v1[l]);
                erdy = p ? 2'b10 : 2'b01;
            end
            chk("ready", l, 32'({rdy1[l], rdy0[l]}), 32'(erdy));
            chk("csb_n", l, 32'(csb_n[l]), 32'(!e_acc[l][cyc]));
            if (e_acc[l][cyc]) begin
                chk("addr", l, 32'(sa[l]), 32'(e_ad[l][cyc]));
                chk("we_n", l, 32'(we_n[l]), 32'(!e_we[l][cyc]));
                if (e_we[l][cyc]) chk("sram_din", l, sdi[l], e_wd[l][cyc]);
            end
            chk("wack", l, 32'({wk1[l], wk0[l]}), 32'(e_wk[l][cyc]));
            chk("rvalid", l, 32'({rv1[l], rv0[l]}), 32'(e_rv[l][cyc]));
            if (e_rv[l][cyc] == 2'b01) chk("rdata0", l, rd0[l], e_rd[l][cyc]);
            if (e_rv[l][cyc] == 2'b10) chk("rdata1", l, rd1[l], e_rd[l][cyc]);
            chk("busy", l, 32'(bsy[l]), 32'(e_bz[l][cyc]));
            if (erdy != 2'b00) schedule(l, p, cyc);
            acc0[l] = v0[l] && rdy0[l];
            acc1[l] = v1[l] && rdy1[l];
            wks0[l] = wk0[l];
            wks1[l] = wk1[l];
        end
    endtask

    task automatic tick();
        if (cyc >= NC - 16) begin
            $display("FAIL cycle_budget observed=%0d required<%0d", cyc, NC - 16);
            $fatal(1, "cycle budget exhausted");
        end
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (rst) begin
            for (int l = 0; l < NL; l++) begin
                for (int t = cyc + 1; t < NC; t++) begin
                    e_acc[l][t] = 1'b0; e_bz[l][t] = 1'b0;
                    e_wk[l][t]  = 2'b00; e_rv[l][t] = 2'b00;
                end
                free_at[l] = cyc + 1;
                lastg[l]   = 1'b1;
                wr_last[l][0] = -1;
                wr_last[l][1] = -1;
            end
        end
        for (int l = 0; l < NL; l++) begin
            if (acc0[l] && !hold) v0[l] = 1'b0;
            if (acc1[l] && !hold) v1[l] = 1'b0;
            if (wks0[l] && wp0[l] < 3) wp0[l]++;
            if (wks1[l] && wp1[l] < 3) wp1[l]++;
            wd0[l] = wb0[wp0[l]];
            wd1[l] = wb1[wp1[l]];
        end
        cyc++;
    endtask

    task automatic wait_acc(input int p);
        int g;
        g = 0;
        while ((p ? v1 : v0) != '0 && g < 64) begin
            tick();
            g++;
        end
        chk("accept_timeout", p, 32'(p ? v1 : v0), 32'd0);
    endtask

    task automatic wait_idle();
        int mx, g;
        mx = 0;
        g  = 0;
        for (int l = 0; l < NL; l++) if (free_at[l] > mx) mx = free_at[l];
        while (cyc < mx && g < 64) begin
            tick();
            g++;
        end
    endtask

    task automatic issue(input int p, input bit w, input logic [4:0] a, input logic [1:0] n,
                         input logic [127:0] d);
        bit pend;
        int g;
        wait_acc(p);
        g = 0;
        pend = 1'b1;
        while (pend && g < 16) begin
            pend = 1'b0;
            for (int l = 0; l < NL; l++) if (wr_last[l][p] >= cyc) pend = 1'b1;
            if (pend) tick();
            g++;
        end
        for (int k = 0; k < 4; k++) begin
            if (p != 0) wb1[k] = d[k*32 +: 32];
            else        wb0[k] = d[k*32 +: 32];
        end
        if (p != 0) begin
            we1_c = w; ad1_c = a; ln1_c = n;
        end else begin
            we0_c = w; ad0_c = a; ln0_c = n;
        end
        for (int l = 0; l < NL; l++) begin
            if (p != 0) begin wp1[l] = 0; wd1[l] = wb1[0]; v1[l] = 1'b1; end
            else        begin wp0[l] = 0; wd0[l] = wb0[0]; v0[l] = 1'b1; end
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1; hold = 1'b0; cyc = 0; n_vec = 0; n_err = 0;
        v0 = '0; v1 = '0;
        we0_c = 1'b0; we1_c = 1'b0; ad0_c = 5'd0; ad1_c = 5'd0; ln0_c = 2'd0; ln1_c = 2'd0;
        for (int k = 0; k < 4; k++) begin wb0[k] = 32'd0; wb1[k] = 32'd0; end
        for (int l = 0; l < NL; l++) begin
            wd0[l] = 32'd0; wd1[l] = 32'd0; wp0[l] = 0; wp1[l] = 0;
            free_at[l] = 0; lastg[l] = 1'b1; wr_last[l][0] = -1; wr_last[l][1] = -1;
            acc0[l] = 1'b0; acc1[l] = 1'b0; wks0[l] = 1'b0; wks1[l] = 1'b0;
            for (int a = 0; a < 32; a++) ref_mem[l][a] = 32'd0;
            for (int t = 0; t < NC; t++) begin
                e_acc[l][t] = 1'b0; e_we[l][t] = 1'b0; e_bz[l][t] = 1'b0;
                e_ad[l][t] = 5'd0; e_wd[l][t] = 32'd0; e_rd[l][t] = 32'd0;
                e_wk[l][t] = 2'b00; e_rv[l][t] = 2'b00;
            end
        end

        // Reset state
        @(posedge clk);
        #1;
        tick();
        for (int l = 0; l < NL; l++) begin
            chk("rst_rdata0", l, rd0[l], 32'd0);
            chk("rst_rdata1", l, rd1[l], 32'd0);
            chk("rst_sram_din", l, sdi[l], 32'd0);
            chk("rst_addr", l, 32'(sa[l]), 32'd0);
            chk("rst_we_n", l, 32'(we_n[l]), 32'd1);
        end
        rst = 1'b0;

        // Fill the whole array with 4-word bursts alternating between ports.
        for (int i = 0; i < 8; i++) issue(i % 2, 1'b1, 5'(i * 4), 2'd3, rnd128());
        wait_idle();

        // Single write then single read at address 5.
        issue(0, 1'b1, 5'd5, 2'd0, {96'd0, 32'hDEADBEEF});
        issue(0, 1'b0, 5'd5, 2'd0, 128'd0);
        wait_idle();

        // Wrapping burst write and read-back on port 1.
        issue(1, 1'b1, 5'd30, 2'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        issue(1, 1'b0, 5'd30, 2'd3, 128'd0);
        wait_idle();

        // Port 1 requests during port 0's 4-beat write.
        issue(0, 1'b1, 5'd12, 2'd3, rnd128());
        tick();
        issue(1, 1'b0, 5'd12, 2'd1, 128'd0);
        wait_idle();

        // Contention straight after reset: both held valid with 1-word reads.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ad0_c = 5'd3; ad1_c = 5'd30; we0_c = 1'b0; we1_c = 1'b0; ln0_c = 2'd0; ln1_c = 2'd0;
        hold = 1'b1;
        v0 = '1; v1 = '1;
        repeat (20) tick();
        hold = 1'b0;
        wait_acc(0);
        wait_acc(1);
        wait_idle();

        // Reset during beat 2 of a 4-beat read, then a fresh read.
        issue(0, 1'b0, 5'd8, 2'd3, 128'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        issue(0, 1'b0, 5'd8, 2'd3, 128'd0);
        wait_idle();

        // Randomised mix of reads/writes, single and dual requests, varied spacing.
        for (int i = 0; i < 150; i++) begin
            int p, gap;
            p = int'($urandom_range(0, 1));
            issue(p, 1'($urandom), 5'($urandom), 2'($urandom), rnd128());
            if ($urandom_range(0, 3) == 0)
                issue(1 - p, 1'($urandom), 5'($urandom), 2'($urandom), rnd128());
            gap = int'($urandom_range(0, 4));
            if (gap == 4) wait_idle();
            else repeat (gap) tick();
        end
        wait_acc(0);
        wait_acc(1);
        wait_idle();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
